// File: rtl/digit_serial_adder.sv
// Multi-cycle adder/subtractor: WIDTH-bit operands are consumed DIGIT bits per
// clock, LSB digit first, with one carry flop linking consecutive digits.
module digit_serial_adder #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    // Handshake: a transfer happens on a rising edge where valid && ready are
    // both high; in_ready is high only in IDLE, out_valid only in DONE.

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    generate
        if (WIDTH < 1 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
            $error("digit_serial_adder: need 1 <= DIGIT <= WIDTH and WIDTH %% DIGIT == 0");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic [DIGIT:0]   dsum;
    logic             c_msb;
    logic [WIDTH-1:0] sum_next;

    always_comb begin
        dsum     = {1'b0, a_sr[DIGIT-1:0]} + {1'b0, b_sr[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};
        // Carry into the digit's top bit recovered from that bit's operands and result.
        c_msb    = a_sr[DIGIT-1] ^ b_sr[DIGIT-1] ^ dsum[DIGIT-1];
        sum_next = (sum >> DIGIT) | (WIDTH'(dsum[DIGIT-1:0]) << (WIDTH - DIGIT));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            a_sr      <= '0;
            b_sr      <= '0;
            carry     <= 1'b0;
            cnt       <= '0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_sr     <= a;
                        b_sr     <= sub ? ~b : b;
                        carry    <= sub ? 1'b1 : cin;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    a_sr  <= a_sr >> DIGIT;
                    b_sr  <= b_sr >> DIGIT;
                    sum   <= sum_next;
                    carry <= dsum[DIGIT];
                    cnt   <= cnt + 1'b1;
                    if (cnt == CW'(N - 1)) begin
                        cout      <= dsum[DIGIT];
                        ovf       <= dsum[DIGIT] ^ c_msb;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_digit_serial_adder.sv
// Bench for digit_serial_adder: WIDTH=8 instances with DIGIT 1, 2, 4 and 8,
// directed corner cases on DIGIT=2 plus a random sweep against an arithmetic model.
module tb_digit_serial_adder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] a, b;
    logic       cin, sub;
    logic       in_valid_w [4];
    logic       out_ready_w[4];
    logic       in_ready_w [4];
    logic       out_valid_w[4];
    logic       cout_w     [4];
    logic       ovf_w      [4];
    logic [7:0] sum_w      [4];

    int         cyc = 0;
    int         checks = 0;
    int         failures = 0;
    logic [9:0] exp_q[$];

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        digit_serial_adder #(.WIDTH(8), .DIGIT(1 << g)) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .in_valid (in_valid_w[g]),
            .in_ready (in_ready_w[g]),
            .a        (a),
            .b        (b),
            .cin      (cin),
            .sub      (sub),
            .out_valid(out_valid_w[g]),
            .out_ready(out_ready_w[g]),
            .sum      (sum_w[g]),
            .cout     (cout_w[g]),
            .ovf      (ovf_w[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: {ovf, cout, sum} from whole-word arithmetic and operand signs.
    function automatic logic [9:0] model(input logic [7:0] a_i, input logic [7:0] b_i,
                                         input logic c_i, input logic s_i);
        logic [7:0] bb;
        logic [8:0] r;
        logic       v;
        bb = s_i ? ~b_i : b_i;
        r  = {1'b0, a_i} + {1'b0, bb} + {8'd0, (s_i ? 1'b1 : c_i)};
        v  = (a_i[7] == bb[7]) && (r[7] != a_i[7]);
        return {v, r[8], r[7:0]};
    endfunction

    // driver: caller is at a negedge and has pushed the expected result onto exp_q
    task automatic do_op(input int k, input logic [7:0] a_i, input logic [7:0] b_i,
                         input logic c_i, input logic s_i, input int hold, output int acc_cyc);
        logic [9:0] e;
        int         lat;
        int         w;
        logic       ir_bad;
        w = 0;
        while (!in_ready_w[k] && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("idle_ready", 32'(in_ready_w[k]), 32'd1);
        a = a_i; b = b_i; cin = c_i; sub = s_i;
        in_valid_w[k] = 1'b1;
        @(negedge clk);
        acc_cyc = cyc;
        in_valid_w[k] = 1'b0;
        a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom); sub = 1'($urandom);
        lat = 0;
        ir_bad = 1'b0;
        while (!out_valid_w[k] && lat < 100) begin
            if (in_ready_w[k]) ir_bad = 1'b1;
            @(negedge clk);
            lat++;
        end
        check("latency", 32'(lat), 32'(8 >> k));
        check("ready_low_run", 32'(ir_bad), 32'd0);
        check("ready_low_done", 32'(in_ready_w[k]), 32'd0);
        e = exp_q.pop_front();
        check("sum", 32'(sum_w[k]), 32'(e[7:0]));
        check("cout", 32'(cout_w[k]), 32'(e[8]));
        check("ovf", 32'(ovf_w[k]), 32'(e[9]));
        for (int i = 0; i < hold; i++) begin
            in_valid_w[k] = 1'($urandom_range(0, 1));
            a = 8'($urandom);
            @(negedge clk);
            check("hold_sum", 32'({ovf_w[k], cout_w[k], sum_w[k]}), 32'(e));
            check("hold_valid", 32'(out_valid_w[k]), 32'd1);
            check("hold_ready", 32'(in_ready_w[k]), 32'd0);
        end
        in_valid_w[k] = 1'b0;
        out_ready_w[k] = 1'b1;
        @(negedge clk);
        out_ready_w[k] = 1'b0;
        check("valid_drop", 32'(out_valid_w[k]), 32'd0);
        check("ready_back", 32'(in_ready_w[k]), 32'd1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, t1;
        logic [7:0] ra, rb;
        logic       rc, rs;
        rst_n = 1'b0;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        for (int k = 0; k < 4; k++) begin
            in_valid_w[k]  = 1'b0;
            out_ready_w[k] = 1'b0;
        end
        #22;
        for (int k = 0; k < 4; k++) begin
            check("rst_ready", 32'(in_ready_w[k]), 32'd1);
            check("rst_valid", 32'(out_valid_w[k]), 32'd0);
            check("rst_sum", 32'({ovf_w[k], cout_w[k], sum_w[k]}), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // carry chain and signed overflow
        exp_q.push_back({1'b0, 1'b1, 8'h00}); do_op(1, 8'hFF, 8'h01, 1'b0, 1'b0, 0, t0);
        exp_q.push_back({1'b1, 1'b0, 8'h80}); do_op(1, 8'h7F, 8'h01, 1'b0, 1'b0, 0, t0);
        exp_q.push_back({1'b1, 1'b1, 8'h7F}); do_op(1, 8'h80, 8'hFF, 1'b0, 1'b0, 0, t0);

        // reset two beats into an operation
        a = 8'h5A; b = 8'h21; cin = 1'b0; sub = 1'b0;
        in_valid_w[1] = 1'b1;
        @(negedge clk);
        in_valid_w[1] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_ready", 32'(in_ready_w[1]), 32'd1);
        check("midrst_valid", 32'(out_valid_w[1]), 32'd0);
        check("midrst_sum", 32'({ovf_w[1], cout_w[1], sum_w[1]}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        exp_q.push_back({1'b0, 1'b0, 8'h07}); do_op(1, 8'h03, 8'h04, 1'b0, 1'b0, 0, t0);

        // subtract ignores cin; add uses it
        exp_q.push_back({1'b0, 1'b0, 8'hFE}); do_op(1, 8'h05, 8'h07, 1'b1, 1'b1, 0, t0);
        exp_q.push_back({1'b0, 1'b0, 8'h20}); do_op(1, 8'h10, 8'h0F, 1'b1, 1'b0, 0, t0);

        // backpressure, then back-to-back issue interval
        exp_q.push_back({1'b0, 1'b0, 8'hFF}); do_op(1, 8'hC3, 8'h3C, 1'b0, 1'b0, 10, t0);
        exp_q.push_back({1'b0, 1'b1, 8'h01}); do_op(1, 8'h09, 8'h08, 1'b0, 1'b1, 0, t0);
        exp_q.push_back({1'b0, 1'b0, 8'h33}); do_op(1, 8'h11, 8'h22, 1'b0, 1'b0, 0, t1);
        check("issue_interval", 32'(t1 - t0), 32'd6);

        // random sweep across all digit sizes
        for (int k = 0; k < 4; k++) begin
            repeat (1000) begin
                ra = 8'($urandom); rb = 8'($urandom);
                rc = 1'($urandom); rs = 1'($urandom);
                exp_q.push_back(model(ra, rb, rc, rs));
                do_op(k, ra, rb, rc, rs, $urandom_range(0, 2), t0);
            end
        end

        // final report
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
